// File: rtl/mux_salida_pkg.sv
//------------------------------------------------------------------------------
// mux_salida_pkg : shared encodings for the output-mux arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mux_salida_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // Channel-index width, never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mux_salida_arb_rr_arbiter.sv
//------------------------------------------------------------------------------
// rr_arbiter : first requester after ptr, searching upward with wrap-around
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SEL_W-1:0]    ptr,
   output logic                gnt_valid,
   output logic [SEL_W-1:0]    gnt_idx
);

   always_comb begin : p_search
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      // Distance 1 is the highest priority, distance CHANNELS (ptr itself) the lowest.
      for (int off = 1; off <= CHANNELS; off++) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (!gnt_valid && req[i] && (((int'(ptr) + off) % CHANNELS) == i)) begin
               gnt_valid = 1'b1;
               gnt_idx   = SEL_W'(i);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mux_salida_arb.sv
//------------------------------------------------------------------------------
// mux_salida_arb : N-channel to 1 registered mux, fixed or round-robin select
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mux_salida_arb
   import mux_salida_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = sel_width(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_data;
   logic [SEL_W-1:0]   r_chan;
   logic [SEL_W-1:0]   r_last;

   logic               w_slot;
   logic               w_fix_req;
   logic               w_rr_valid;
   logic [SEL_W-1:0]   w_rr_idx;
   logic               w_gnt;
   logic [SEL_W-1:0]   w_gnt_idx;
   logic [WIDTH-1:0]   w_gnt_data;

   rr_arbiter #(
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) u_rr (
      .req       (in_valid),
      .ptr       (r_last),
      .gnt_valid (w_rr_valid),
      .gnt_idx   (w_rr_idx)
   );

   // An out-of-range sel matches no channel, so it can never produce a grant.
   always_comb begin : p_grant
      w_fix_req  = 1'b0;
      w_gnt_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sel == SEL_W'(i)) w_fix_req = in_valid[i];
      end
      w_slot    = (r_state == ST_EMPTY) || out_ready;
      w_gnt_idx = (mode == MODE_RR) ? w_rr_idx : sel;
      w_gnt     = rst_n && w_slot && ((mode == MODE_RR) ? w_rr_valid : w_fix_req);
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_gnt_idx == SEL_W'(i)) w_gnt_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : p_state_reg
      if (!rst_n) r_state <= ST_EMPTY;
      else        r_state <= w_state_nxt;
   end

   always_comb begin : p_next_state
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_gnt)               w_state_nxt = ST_FULL;
         ST_FULL:  if (out_ready && !w_gnt) w_state_nxt = ST_EMPTY;
         default:                           w_state_nxt = ST_EMPTY;
      endcase
   end

   always_comb begin : p_outputs
      out_valid = (r_state == ST_FULL);
      in_ready  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         in_ready[i] = w_gnt && (w_gnt_idx == SEL_W'(i));
      end
   end

   // Held word only changes on a grant; a pure drain leaves stale data behind EMPTY.
   always_ff @(posedge clk or negedge rst_n) begin : p_data_reg
      if (!rst_n) begin
         r_data <= '0;
         r_chan <= '0;
         r_last <= SEL_W'(CHANNELS - 1);
      end else if (w_gnt) begin
         r_data <= w_gnt_data;
         r_chan <= w_gnt_idx;
         r_last <= w_gnt_idx;
      end
   end

   assign out_data = r_data;
   assign out_chan = r_chan;

endmodule

`default_nettype wire

// File: tb/tb_mux_salida_arb.sv
//------------------------------------------------------------------------------
// tb_mux_salida_arb : directed stimulus with queue scoreboard and monitor
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_salida_arb;

   logic        clk;
   logic        rst_n;

   // Main instance: 4 channels x 8 bits
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic        mode;
   logic [1:0]  sel;
   logic [7:0]  out_data;
   logic [1:0]  out_chan;
   logic        out_valid;
   logic        out_ready;

   // Second instance: 5 channels so sel can express out-of-range indices
   logic [39:0] od_in_data;
   logic [4:0]  od_in_valid;
   logic [4:0]  od_in_ready;
   logic        od_mode;
   logic [2:0]  od_sel;
   logic [7:0]  od_out_data;
   logic [2:0]  od_out_chan;
   logic        od_out_valid;
   logic        od_out_ready;

   int n_checks = 0;
   int n_err    = 0;
   logic [9:0] sb[$];

   mux_salida_arb #(.WIDTH(8), .CHANNELS(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   mux_salida_arb #(.WIDTH(8), .CHANNELS(5)) u_odd (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (od_in_data),
      .in_valid  (od_in_valid),
      .in_ready  (od_in_ready),
      .mode      (od_mode),
      .sel       (od_sel),
      .out_data  (od_out_data),
      .out_chan  (od_out_chan),
      .out_valid (od_out_valid),
      .out_ready (od_out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] ch, input logic [7:0] d);
      sb.push_back({ch, d});
   endtask

   task automatic set_ch(input int idx, input logic [7:0] d);
      in_data[idx*8 +: 8] = d;
   endtask

   // Every accepted output word must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         logic [9:0] exp_w;
         n_checks++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected actual chan=%0d data=%0d required none", out_chan, out_data);
         end else begin
            exp_w = sb.pop_front();
            if ({out_chan, out_data} !== exp_w) begin
               n_err++;
               $display("FAIL sb_word actual chan=%0d data=%0d required chan=%0d data=%0d @%0t",
                        out_chan, out_data, exp_w[9:8], exp_w[7:0], $time);
            end
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      in_data      = '0;
      in_valid     = 4'hF;
      mode         = 1'b0;
      sel          = 2'd0;
      out_ready    = 1'b0;
      od_in_data   = '0;
      od_in_valid  = 5'h1F;
      od_mode      = 1'b0;
      od_sel       = 3'd0;
      od_out_ready = 1'b0;

      // Reset state
      cyc(2);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data",  {24'd0, out_data},  32'd0);
      check("rst_out_chan",  {30'd0, out_chan},  32'd0);
      check("rst_in_ready",  {28'd0, in_ready},  32'd0);
      check("rst_od_in_ready", {27'd0, od_in_ready}, 32'd0);
      in_valid    = 4'h0;
      od_in_valid = 5'h0;
      rst_n       = 1'b1;
      cyc(1);

      // Fixed mode, sel 0 -> 1 -> 0 every 5 cycles
      set_ch(0, 8'd10);
      set_ch(1, 8'd50);
      in_valid  = 4'b0011;
      out_ready = 1'b1;
      mode      = 1'b0;
      sel = 2'd0; repeat (5) push(2'd0, 8'd10); cyc(5);
      sel = 2'd1; repeat (5) push(2'd1, 8'd50); cyc(5);
      sel = 2'd0; repeat (5) push(2'd0, 8'd10); cyc(5);
      in_valid = 4'b0000;
      cyc(2);

      // Fixed mode streaming without bubbles
      sel      = 2'd0;
      in_valid = 4'b0001;
      set_ch(0, 8'd10); push(2'd0, 8'd10); cyc(1);
      check("stream_valid0", {31'd0, out_valid}, 32'd1);
      set_ch(0, 8'd30); push(2'd0, 8'd30); cyc(1);
      check("stream_valid1", {31'd0, out_valid}, 32'd1);
      set_ch(0, 8'd80); push(2'd0, 8'd80); cyc(1);
      check("stream_valid2", {31'd0, out_valid}, 32'd1);
      check("stream_data2",  {24'd0, out_data},  32'd80);
      in_valid = 4'b0000;
      cyc(2);
      check("drain_empty", {31'd0, out_valid}, 32'd0);

      // Backpressure while holding 30
      set_ch(0, 8'd30);
      in_valid  = 4'b0001;
      out_ready = 1'b0;
      push(2'd0, 8'd30);
      cyc(1);
      set_ch(0, 8'd99);
      for (int k = 0; k < 3; k++) begin
         check("bp_hold_data",  {24'd0, out_data},  32'd30);
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_in_ready",   {28'd0, in_ready},  32'd0);
         cyc(1);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", {28'd0, in_ready}, 32'b0001);
      push(2'd0, 8'd99);
      cyc(1);
      check("bp_next_word", {24'd0, out_data}, 32'd99);
      in_valid = 4'b0000;
      cyc(2);

      // Reset while FULL, then round-robin from channel 0
      set_ch(0, 8'd77);
      in_valid  = 4'b0001;
      out_ready = 1'b0;
      cyc(1);
      check("pre_rst_full", {31'd0, out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid",    {31'd0, out_valid}, 32'd0);
      check("async_rst_data",     {24'd0, out_data},  32'd0);
      check("async_rst_in_ready", {28'd0, in_ready},  32'd0);
      @(posedge clk);
      #1;
      mode = 1'b1;
      set_ch(0, 8'd1); set_ch(1, 8'd2); set_ch(2, 8'd3); set_ch(3, 8'd4);
      in_valid  = 4'hF;
      out_ready = 1'b1;
      push(2'd0, 8'd1); push(2'd1, 8'd2); push(2'd2, 8'd3); push(2'd3, 8'd4); push(2'd0, 8'd1);
      #2;
      rst_n = 1'b1;
      #1;
      check("post_rst_no_early_load", {31'd0, out_valid}, 32'd0);
      cyc(5);
      in_valid = 4'h0;
      cyc(2);

      // Out-of-range sel on the 5-channel instance
      od_in_data[2*8 +: 8] = 8'h42;
      od_in_valid  = 5'h1F;
      od_sel       = 3'd2;
      od_out_ready = 1'b0;
      cyc(1);
      check("od_load_valid", {31'd0, od_out_valid}, 32'd1);
      check("od_load_data",  {24'd0, od_out_data},  32'h42);
      check("od_load_chan",  {29'd0, od_out_chan},  32'd2);
      od_sel       = 3'd5;
      od_out_ready = 1'b1;
      #1;
      check("od_sel5_in_ready", {27'd0, od_in_ready}, 32'd0);
      cyc(1);
      check("od_sel5_drained", {31'd0, od_out_valid}, 32'd0);
      od_sel = 3'd7;
      #1;
      check("od_sel7_in_ready", {27'd0, od_in_ready}, 32'd0);
      cyc(1);
      check("od_sel7_empty", {31'd0, od_out_valid}, 32'd0);

      check("sb_leftover", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
